// File: rtl/wb_gpio_led.sv
// wb_gpio_led: Wishbone classic slave for the general-purpose pads and user LEDs.
//
// Registers output data and output enables for the top-level tristate buffers,
// synchronises pad inputs into the wb_clk_i domain and, when WB_GPIO_IRQ_EN is
// defined, latches rising pad edges into a maskable level interrupt.
//
// Configuration macro: WB_GPIO_IRQ_EN (undefined: no EDGE/MASK, irq_o tied 0).
//
// Register map (word offset = wb_adr_i[4:2]):
//   0 OUT  RW   pad output data
//   1 OE   RW   pad output enable, 1 = drive
//   2 IN   RO   synchronised pad value
//   3 LED  RW   LED register
//   4 EDGE W1C  rising-edge flags        (WB_GPIO_IRQ_EN only)
//   5 MASK RW   interrupt enable per pad (WB_GPIO_IRQ_EN only)
//   6,7        unmapped, read 0, writes ignored but acked
//
// Ports:
//   wb_clk_i, wb_rst_n_i          clock, async active-low reset
//   wb_adr_i/dat_i/sel_i/we_i     Wishbone request
//   wb_cyc_i, wb_stb_i            Wishbone cycle / strobe
//   wb_dat_o, wb_ack_o            registered read data / acknowledge
//   gpio_i                        pad input (asynchronous)
//   gpio_o, gpio_oe_o             pad output data / enable
//   led_o                         LED drive
//   irq_o                         registered level interrupt

module wb_gpio_led #(
    parameter int unsigned GPIO_WIDTH     = 8,
    parameter int unsigned LED_WIDTH      = 3,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe_o,
    output logic [LED_WIDTH-1:0]  led_o,
    output logic                  irq_o
);

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] ADR_OUT  = 3'd0;
    localparam logic [2:0] ADR_OE   = 3'd1;
    localparam logic [2:0] ADR_IN   = 3'd2;
    localparam logic [2:0] ADR_LED  = 3'd3;
`ifdef WB_GPIO_IRQ_EN
    localparam logic [2:0] ADR_EDGE = 3'd4;
    localparam logic [2:0] ADR_MASK = 3'd5;
`endif

    // Register state
    logic [GPIO_WIDTH-1:0] out_q,  out_d;
    logic [GPIO_WIDTH-1:0] oe_q,   oe_d;
    logic [LED_WIDTH-1:0]  led_q,  led_d;
    logic [GPIO_WIDTH-1:0] s1_q,   s1_d;
    logic [GPIO_WIDTH-1:0] s2_q,   s2_d;
    logic                  ack_q,  ack_d;
    logic [DATA_W-1:0]     dat_q,  dat_d;
`ifdef WB_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] prev_q, prev_d;
    logic [GPIO_WIDTH-1:0] edge_q, edge_d;
    logic [GPIO_WIDTH-1:0] mask_q, mask_d;
    logic                  irq_q,  irq_d;
    logic [GPIO_WIDTH-1:0] rise_c;
    logic [GPIO_WIDTH-1:0] clr_c;
`endif

    logic       acc_c;
    logic       wr_c;
    logic [2:0] adr_c;
    logic       unused_c;

    // Only adr[4:2], sel[0] and the low data bits are meaningful
    assign unused_c = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, wb_sel_i[3:1]};

    assign adr_c = wb_adr_i[4:2];
    // One-cycle ack; an access is only taken when ack is low, so ack never repeats
    assign acc_c = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_c  = acc_c & wb_we_i & wb_sel_i[0];

    // Next-state logic
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        led_d = led_q;
        s1_d  = gpio_i;
        s2_d  = s1_q;
        ack_d = acc_c;
        dat_d = dat_q;
`ifdef WB_GPIO_IRQ_EN
        prev_d = s2_q;
        mask_d = mask_q;
        rise_c = s2_q & ~prev_q;
        clr_c  = '0;
        irq_d  = |(edge_q & mask_q);
`endif

        // Read data is captured on the ack edge and held otherwise
        if (acc_c) begin
            case (adr_c)
                ADR_OUT:  dat_d = DATA_W'(out_q);
                ADR_OE:   dat_d = DATA_W'(oe_q);
                ADR_IN:   dat_d = DATA_W'(s2_q);
                ADR_LED:  dat_d = DATA_W'(led_q);
`ifdef WB_GPIO_IRQ_EN
                ADR_EDGE: dat_d = DATA_W'(edge_q);
                ADR_MASK: dat_d = DATA_W'(mask_q);
`endif
                default:  dat_d = '0;
            endcase
        end

        if (wr_c) begin
            case (adr_c)
                ADR_OUT:  out_d = wb_dat_i[GPIO_WIDTH-1:0];
                ADR_OE:   oe_d  = wb_dat_i[GPIO_WIDTH-1:0];
                ADR_LED:  led_d = wb_dat_i[LED_WIDTH-1:0];
`ifdef WB_GPIO_IRQ_EN
                ADR_EDGE: clr_c  = wb_dat_i[GPIO_WIDTH-1:0];
                ADR_MASK: mask_d = wb_dat_i[GPIO_WIDTH-1:0];
`endif
                default:  ;
            endcase
        end

`ifdef WB_GPIO_IRQ_EN
        // A new rising edge overrides a simultaneous W1C of the same bit
        edge_d = (edge_q & ~clr_c) | rise_c;
`endif
    end

    // State registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            out_q  <= '0;
            oe_q   <= '0;
            led_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
`ifdef WB_GPIO_IRQ_EN
            prev_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
`endif
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            led_q  <= led_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
`ifdef WB_GPIO_IRQ_EN
            prev_q <= prev_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
`endif
        end
    end

    // Outputs
    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = oe_q;
    assign led_o     = led_q ^ {LED_WIDTH{LED_ACTIVE_LOW}};
`ifdef WB_GPIO_IRQ_EN
    assign irq_o     = irq_q;
`else
    assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_gpio_led.sv
// Self-checking bench for wb_gpio_led: register table, handshake pattern,
// synchroniser latency, edge/interrupt behaviour and reset corner cases.

module tb_wb_gpio_led;

    localparam bit LAL = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [7:0]  gpio_i;
    logic [7:0]  gpio_o;
    logic [7:0]  gpio_oe_o;
    logic [2:0]  led_o;
    logic        irq_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] sb_q[$];

    typedef struct {
        bit          we;
        logic [2:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [7:0]  exp_gpio;
        logic [7:0]  exp_oe;
        logic [2:0]  exp_led;
    } vec_t;

    vec_t vt[15];

    wb_gpio_led #(
        .GPIO_WIDTH    (8),
        .LED_WIDTH     (3),
        .LED_ACTIVE_LOW(LAL)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_i),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe_o),
        .led_o     (led_o),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One bus access, started just after a falling edge; returns at the ack negedge
    task automatic wb_xfer(input bit w, input logic [2:0] off, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] exp_rd, input string name);
        int lat;
        bit got;
        logic [31:0] e;
        if (wb_ack_o) @(negedge clk);
        adr   = {27'd0, off, 2'b00};
        dat_i = d;
        sel   = s;
        we    = w;
        cyc   = 1'b1;
        stb   = 1'b1;
        if (!w) sb_q.push_back(exp_rd);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 4) begin
            @(negedge clk);
            lat++;
            if (wb_ack_o) got = 1'b1;
        end
        if (got) begin
            chk({name, "_ack_lat"}, 32'(lat), 32'd1);
            if (!w) begin
                e = sb_q.pop_front();
                chk({name, "_rdata"}, wb_dat_o, e);
            end
        end else begin
            total_cnt++;
            $display("FAIL %s_timeout: got no ack expected ack within 4 cycles", name);
            if (!w) void'(sb_q.pop_front());
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        adr    = '0;
        dat_i  = '0;
        sel    = '0;
        we     = 1'b0;
        cyc    = 1'b0;
        stb    = 1'b0;
        gpio_i = '0;

        vt[0]  = '{1'b1, 3'd0, 32'h0000_00A5, 4'h1, 32'h0, 8'hA5, 8'h00, 3'h0};
        vt[1]  = '{1'b1, 3'd1, 32'h0000_000F, 4'h1, 32'h0, 8'hA5, 8'h0F, 3'h0};
        vt[2]  = '{1'b1, 3'd0, 32'h0000_00FF, 4'h2, 32'h0, 8'hA5, 8'h0F, 3'h0};
        vt[3]  = '{1'b0, 3'd0, 32'h0,         4'hF, 32'h0000_00A5, 8'hA5, 8'h0F, 3'h0};
        vt[4]  = '{1'b0, 3'd1, 32'h0,         4'hF, 32'h0000_000F, 8'hA5, 8'h0F, 3'h0};
        vt[5]  = '{1'b1, 3'd3, 32'h0000_0005, 4'hF, 32'h0, 8'hA5, 8'h0F, 3'h5};
        vt[6]  = '{1'b0, 3'd3, 32'h0,         4'hF, 32'h0000_0005, 8'hA5, 8'h0F, 3'h5};
        vt[7]  = '{1'b1, 3'd0, 32'h1234_5677, 4'h1, 32'h0, 8'h77, 8'h0F, 3'h5};
        vt[8]  = '{1'b0, 3'd0, 32'h0,         4'hF, 32'h0000_0077, 8'h77, 8'h0F, 3'h5};
        vt[9]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0, 8'h77, 8'h0F, 3'h5};
        vt[10] = '{1'b0, 3'd6, 32'h0,         4'hF, 32'h0000_0000, 8'h77, 8'h0F, 3'h5};
        vt[11] = '{1'b1, 3'd3, 32'hFFFF_FFFA, 4'h1, 32'h0, 8'h77, 8'h0F, 3'h2};
        vt[12] = '{1'b0, 3'd3, 32'h0,         4'hF, 32'h0000_0002, 8'h77, 8'h0F, 3'h2};
        vt[13] = '{1'b1, 3'd2, 32'h0000_00FF, 4'h1, 32'h0, 8'h77, 8'h0F, 3'h2};
        vt[14] = '{1'b0, 3'd2, 32'h0,         4'hF, 32'h0000_0000, 8'h77, 8'h0F, 3'h2};

        // Reset values are visible while reset is held
        #1;
        chk("rst_ack",  32'(wb_ack_o),  32'd0);
        chk("rst_dat",  wb_dat_o,       32'd0);
        chk("rst_gpio", 32'(gpio_o),    32'd0);
        chk("rst_oe",   32'(gpio_oe_o), 32'd0);
        chk("rst_led",  32'(led_o),     32'(3'b000 ^ {3{LAL}}));
        chk("rst_irq",  32'(irq_o),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All offsets read zero after reset
        for (int i = 0; i < 8; i++) wb_xfer(1'b0, 3'(i), 32'h0, 4'hF, 32'h0, "rd_reset");

        // Register table
        for (int i = 0; i < 15; i++) begin
            wb_xfer(vt[i].we, vt[i].off, vt[i].dat, vt[i].sel, vt[i].exp_rd, "vec");
            chk("vec_gpio", 32'(gpio_o),    32'(vt[i].exp_gpio));
            chk("vec_oe",   32'(gpio_oe_o), 32'(vt[i].exp_oe));
            chk("vec_led",  32'(led_o),     32'(vt[i].exp_led ^ {3{LAL}}));
        end

        // Ack pattern with cyc/stb held high
        @(negedge clk);
        adr = 32'h0;
        we  = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("ack_pattern", 32'(wb_ack_o), 32'(i % 2));
            @(negedge clk);
        end
        cyc = 1'b0;
        stb = 1'b0;
        @(negedge clk);

        // Synchroniser: change before edge k is not visible at k+1, visible at k+2
        gpio_i = 8'h3C;
        @(negedge clk);
        wb_xfer(1'b0, 3'd2, 32'h0, 4'hF, 32'h0000_0000, "in_k1");
        repeat (3) @(negedge clk);
        gpio_i = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        wb_xfer(1'b0, 3'd2, 32'h0, 4'hF, 32'h0000_00C3, "in_k2");

`ifdef WB_GPIO_IRQ_EN
        // Clear stale flags, idle pads low, enable bit 0
        repeat (3) @(negedge clk);
        wb_xfer(1'b1, 3'd4, 32'h0000_00FF, 4'h1, 32'h0, "edge_clr_all");
        gpio_i = 8'h00;
        repeat (4) @(negedge clk);
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0000, "edge_zero");
        wb_xfer(1'b1, 3'd5, 32'h0000_0001, 4'h1, 32'h0, "mask_wr");
        @(negedge clk);
        // Rising edge on bit 0: irq low at k+2, high at k+3
        gpio_i = 8'h01;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("irq_k2", 32'(irq_o), 32'd0);
        @(negedge clk);
        chk("irq_k3", 32'(irq_o), 32'd1);
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0001, "edge_set");
        wb_xfer(1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_0001, "mask_rd");
        // W1C drops irq one cycle after commit
        wb_xfer(1'b1, 3'd4, 32'h0000_0001, 4'h1, 32'h0, "edge_w1c");
        chk("irq_at_clr", 32'(irq_o), 32'd1);
        @(negedge clk);
        chk("irq_after_clr", 32'(irq_o), 32'd0);
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0000, "edge_cleared");
        // Set wins over a simultaneous clear
        gpio_i = 8'h00;
        repeat (4) @(negedge clk);
        gpio_i = 8'h01;
        @(negedge clk);
        @(negedge clk);
        wb_xfer(1'b1, 3'd4, 32'h0000_0001, 4'h1, 32'h0, "edge_race_w1c");
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0001, "edge_set_wins");
`else
        // Offsets 4/5 unmapped, irq tied low
        gpio_i = 8'h00;
        repeat (4) @(negedge clk);
        gpio_i = 8'hFF;
        repeat (4) @(negedge clk);
        wb_xfer(1'b1, 3'd4, 32'h0000_00FF, 4'hF, 32'h0, "edge_wr_nop");
        wb_xfer(1'b1, 3'd5, 32'h0000_00FF, 4'hF, 32'h0, "mask_wr_nop");
        wb_xfer(1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0000, "edge_rd_zero");
        wb_xfer(1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_0000, "mask_rd_zero");
        gpio_i = 8'h00;
        repeat (3) @(negedge clk);
        gpio_i = 8'hFF;
        repeat (4) @(negedge clk);
        chk("irq_tied_low", 32'(irq_o), 32'd0);
`endif

        // Reset in the middle of an ack drops it immediately
        wb_xfer(1'b1, 3'd0, 32'h0000_005A, 4'h1, 32'h0, "pre_rst_wr");
        chk("pre_rst_gpio", 32'(gpio_o), 32'h5A);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack",  32'(wb_ack_o), 32'd0);
        chk("mid_rst_gpio", 32'(gpio_o),   32'd0);
        chk("mid_rst_led",  32'(led_o),    32'(3'b000 ^ {3{LAL}}));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_xfer(1'b0, 3'd0, 32'h0, 4'hF, 32'h0000_0000, "post_rst_out");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
